// File: rtl/lcmv_pkg.sv
// Shared types for the LCMV correlation sequencer: FSM state and the index tuple.
package lcmv_pkg;
  localparam int IDX_W = 8;
  localparam int PIX_W = 16;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } idx_tuple_t;
endpackage

// File: rtl/counter_up_to.sv
// Wrap-around counter: counts 0..last, wraps to 0 on an up while at last.
module counter_up_to #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         reset_count,
  input  logic         up,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         max
);
  assign max = (count == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             count <= '0;
    else if (reset_count) count <= '0;
    else if (up)          count <= max ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/counter_up_to_load.sv
// counter_up_to with a synchronous load: a loaded base plus a counted offset,
// so the shared counter is reused unchanged and count never passes last.
module counter_up_to_load #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         reset_count,
  input  logic         up,
  input  logic [W-1:0] last,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         max
);
  logic [W-1:0] base, off, off_last;

  // Offset runs 0..(last-base); base <= last is guaranteed by the caller.
  assign off_last = last - base;
  assign count    = base + off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             base <= '0;
    else if (reset_count) base <= '0;
    else if (load)        base <= load_val;
  end

  counter_up_to #(.W(W)) u_off (
    .clk(clk), .rst(rst), .reset_count(reset_count || load), .up(up),
    .last(off_last), .count(off), .max(max)
  );
endmodule

// File: rtl/loop_nest_scheduler.sv
// Walks (pixel,row,col) over full or upper-triangle band space as a valid/ready
// stream; three chained counters, bounds latched at start, done pulse at the end.
module loop_nest_scheduler import lcmv_pkg::*; #(
  parameter int IDX_W = lcmv_pkg::IDX_W,
  parameter int PIX_W = lcmv_pkg::PIX_W
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] num_pixels_m1,
  input  logic [IDX_W-1:0] num_bands_m1,
  input  logic             sym_mode,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [PIX_W-1:0] pix_idx,
  output logic [IDX_W-1:0] row_idx,
  output logic [IDX_W-1:0] col_idx,
  output logic             first_of_pixel,
  output logic             last_of_pixel,
  output logic             last
);
  state_t           state;
  logic [PIX_W-1:0] cfg_pix;
  logic [IDX_W-1:0] cfg_bands;
  logic             cfg_sym;
  logic             accept, abort_run, transfer, final_xfer, clr;
  logic             col_max, row_max, pix_max, col_wrap;
  logic [IDX_W-1:0] col_reload;

  assign accept     = (state == IDLE) && start;
  assign abort_run  = (state == RUN) && abort;
  assign transfer   = idx_valid && idx_ready;
  assign final_xfer = transfer && last;
  assign clr        = accept || abort_run || final_xfer;
  assign col_wrap   = transfer && col_max;
  // In triangle mode col restarts at the row it is about to enter.
  assign col_reload = cfg_sym ? (row_max ? '0 : row_idx + 1'b1) : '0;

  assign first_of_pixel = idx_valid && (row_idx == '0) && (col_idx == '0);
  assign last_of_pixel  = idx_valid && row_max && col_max;
  assign last           = last_of_pixel && pix_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      idx_valid <= 1'b0;
      done      <= 1'b0;
      cfg_pix   <= '0;
      cfg_bands <= '0;
      cfg_sym   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          busy      <= 1'b1;
          idx_valid <= 1'b1;
          cfg_pix   <= num_pixels_m1;
          cfg_bands <= num_bands_m1;
          cfg_sym   <= sym_mode;
        end
        RUN: if (abort) begin
          state     <= IDLE;
          busy      <= 1'b0;
          idx_valid <= 1'b0;
        end else if (final_xfer) begin
          state     <= IDLE;
          busy      <= 1'b0;
          idx_valid <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  counter_up_to_load #(.W(IDX_W)) u_col (
    .clk(clk), .rst(rst), .reset_count(clr), .up(transfer), .last(cfg_bands),
    .load(col_wrap), .load_val(col_reload), .count(col_idx), .max(col_max)
  );

  counter_up_to #(.W(IDX_W)) u_row (
    .clk(clk), .rst(rst), .reset_count(clr), .up(col_wrap), .last(cfg_bands),
    .count(row_idx), .max(row_max)
  );

  counter_up_to #(.W(PIX_W)) u_pix (
    .clk(clk), .rst(rst), .reset_count(clr), .up(col_wrap && row_max), .last(cfg_pix),
    .count(pix_idx), .max(pix_max)
  );
endmodule

// File: tb/tb_loop_nest_scheduler.sv
// Directed bench for loop_nest_scheduler: ordered tuple streams, backpressure,
// abort, start handling and async reset against a small nested-loop model.
module tb_loop_nest_scheduler;
  import lcmv_pkg::*;
  localparam int IW = 8;
  localparam int PW = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, sym_mode = 1'b0, abort = 1'b0, idx_ready = 1'b0;
  logic [PW-1:0] num_pixels_m1 = '0;
  logic [IW-1:0] num_bands_m1 = '0;
  logic busy, done, idx_valid, first_of_pixel, last_of_pixel, last;
  logic [PW-1:0] pix_idx;
  logic [IW-1:0] row_idx, col_idx;

  int n_checks = 0, n_errors = 0;
  int nx, nb;
  idx_tuple_t exp_q[$];

  always #5 clk = ~clk;

  loop_nest_scheduler #(.IDX_W(IW), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pixels_m1(num_pixels_m1),
    .num_bands_m1(num_bands_m1), .sym_mode(sym_mode), .abort(abort),
    .busy(busy), .done(done), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .pix_idx(pix_idx), .row_idx(row_idx), .col_idx(col_idx),
    .first_of_pixel(first_of_pixel), .last_of_pixel(last_of_pixel), .last(last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void build(input int p, input int b, input bit sym);
    idx_tuple_t t;
    exp_q.delete();
    for (int x = 0; x <= p; x++)
      for (int r = 0; r <= b; r++)
        for (int c = (sym ? r : 0); c <= b; c++) begin
          t.pix = x[PW-1:0];
          t.row = r[IW-1:0];
          t.col = c[IW-1:0];
          exp_q.push_back(t);
        end
  endfunction

  task automatic start_run(input int p, input int b, input bit sym);
    num_pixels_m1 = p[PW-1:0];
    num_bands_m1  = b[IW-1:0];
    sym_mode      = sym;
    start         = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy_valid", {busy, idx_valid, done}, 3'b110);
  endtask

  // Streams from expected index k0 to the end; leaves time in the done cycle.
  task automatic collect(input int k0, input int pct, input int p, input int b,
                         output int nxf, output int nbusy);
    int k, cyc;
    bit stalled, f, lp, la;
    logic [36:0] cur, snap;
    idx_tuple_t t;
    k = k0; cyc = 0; stalled = 0; nxf = 0; nbusy = 0; snap = '0;
    while (k < exp_q.size() && cyc < 5000) begin
      cur = {pix_idx, row_idx, col_idx, first_of_pixel, last_of_pixel, last, idx_valid, busy};
      if (stalled) chk("stall_hold", cur, snap);
      if (busy) nbusy++;
      chk("run_state", {busy, idx_valid, done}, 3'b110);
      idx_ready = ($urandom_range(0, 99) < pct);
      if (idx_ready) begin
        t  = exp_q[k];
        f  = (t.row == 0) && (t.col == 0);
        lp = (t.row == b[IW-1:0]) && (t.col == b[IW-1:0]);
        la = lp && (t.pix == p[PW-1:0]);
        chk("tuple", {pix_idx, row_idx, col_idx}, {t.pix, t.row, t.col});
        chk("flags", {first_of_pixel, last_of_pixel, last}, {f, lp, la});
        k++;
        nxf++;
      end
      stalled = !idx_ready;
      snap = cur;
      tick;
      cyc++;
    end
    idx_ready = 1'b0;
    chk("run_len", k, exp_q.size());
    chk("done_pulse", {done, busy, idx_valid, pix_idx, row_idx, col_idx}, {3'b100, 32'h0});
  endtask

  task automatic idle_chk;
    tick;
    chk("done_clear", {done, busy, idx_valid, first_of_pixel, last_of_pixel, last}, 6'b0);
  endtask

  initial begin
    #12;
    chk("reset_outputs", {busy, done, idx_valid, pix_idx, row_idx, col_idx,
                          first_of_pixel, last_of_pixel, last}, 64'h0);
    rst = 1'b1;
    tick;
    chk("idle_after_reset", {busy, idx_valid, done}, 3'b000);

    // Full traversal, no stalls: 2 pixels x 3x3 bands
    build(1, 2, 0);
    start_run(1, 2, 0);
    collect(0, 100, 1, 2, nx, nb);
    chk("full_len", nx, 18);
    chk("full_busy_cycles", nb, 18);
    idle_chk;

    // Upper triangle, one pixel, 3 bands
    build(0, 2, 1);
    start_run(0, 2, 1);
    collect(0, 100, 0, 2, nx, nb);
    chk("sym_len", nx, 6);
    idle_chk;

    // Backpressure on the full traversal
    build(1, 2, 0);
    start_run(1, 2, 0);
    collect(0, 30, 1, 2, nx, nb);
    chk("bp_len", nx, 18);
    idle_chk;

    // Degenerate bounds: single tuple
    build(0, 0, 0);
    start_run(0, 0, 0);
    collect(0, 100, 0, 0, nx, nb);
    chk("degen_len", nx, 1);
    idle_chk;

    // Abort after 5 transfers, coincident with a transfer
    build(1, 2, 0);
    start_run(1, 2, 0);
    idx_ready = 1'b1;
    repeat (5) tick;
    chk("pre_abort_tuple", {pix_idx, row_idx, col_idx}, {16'd0, 8'd1, 8'd2});
    abort = 1'b1;
    tick;
    abort = 1'b0;
    idx_ready = 1'b0;
    chk("abort_idle", {busy, idx_valid, done, pix_idx, row_idx, col_idx}, 35'h0);
    tick;
    chk("abort_no_done", {done, busy, idx_valid}, 3'b000);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_in_idle", {done, busy, idx_valid}, 3'b000);
    start_run(1, 2, 0);
    chk("restart_tuple", {pix_idx, row_idx, col_idx}, 32'h0);
    collect(0, 100, 1, 2, nx, nb);
    chk("restart_len", nx, 18);
    idle_chk;

    // Start mid-run with new bounds is ignored
    build(0, 1, 0);
    start_run(0, 1, 0);
    idx_ready = 1'b1;
    tick;
    start = 1'b1; num_pixels_m1 = 16'd3; num_bands_m1 = 8'd3; sym_mode = 1'b1;
    tick;
    start = 1'b0;
    idx_ready = 1'b0;
    collect(2, 100, 0, 1, nx, nb);
    chk("midstart_len", nx, 2);

    // Start in the done cycle launches the next run immediately
    num_pixels_m1 = 16'd0; num_bands_m1 = 8'd2; sym_mode = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("done_cycle_start", {busy, idx_valid, done, pix_idx, row_idx, col_idx}, {3'b110, 32'h0});
    build(0, 2, 1);
    collect(0, 100, 0, 2, nx, nb);
    chk("second_run_len", nx, 6);
    idle_chk;

    // Async reset mid-run clears outputs without a clock edge
    start_run(1, 2, 0);
    idx_ready = 1'b1;
    repeat (3) tick;
    idx_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {busy, done, idx_valid, pix_idx, row_idx, col_idx,
                        first_of_pixel, last_of_pixel, last}, 64'h0);
    rst = 1'b1;
    tick;
    chk("post_reset_idle", {busy, idx_valid, done}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/loop_nest_scheduler.md
Name: loop_nest_scheduler

Overview:
Sequencer that walks the (pixel, row, col) index space for the correlation/accumulate datapath of the LCMV classifier, one index tuple per accepted transfer. It is built from three chained wrap-around counters. It supports full N x N traversal and symmetric upper-triangle traversal (col >= row) for building the correlation matrix. Bounds are latched at start, the output is a valid/ready stream, and completion is reported with a done pulse.

Parameters:
IDX_W, 8, width of row/col index and band bound
PIX_W, 16, width of pixel index and pixel bound

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request a traversal; accepted only in IDLE
num_pixels_m1  in  PIX_W  pixel count minus 1; sampled on accepted start
num_bands_m1  in  IDX_W  band count minus 1; sampled on accepted start
sym_mode  in  1  1 = upper triangle only (col from row); sampled on accepted start
abort  in  1  synchronous cancel of a running traversal
busy  out  1  high in RUN
done  out  1  one-cycle pulse after final transfer
idx_valid  out  1  index tuple valid
idx_ready  in  1  consumer accepts tuple
pix_idx  out  PIX_W  current pixel
row_idx  out  IDX_W  current row band
col_idx  out  IDX_W  current col band
first_of_pixel  out  1  tuple is the first of its pixel
last_of_pixel  out  1  tuple is the last of its pixel
last  out  1  tuple is the final tuple of the traversal

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Latched bounds and sym flag 0.
- FSM states:
  - IDLE -> RUN on start=1.
  - RUN -> IDLE on final transfer or abort.
- Accepted start:
  - Latch num_pixels_m1, num_bands_m1, sym_mode.
  - Clear all counters.
  - Next cycle: busy=1, idx_valid=1, tuple (0,0,0).
- start in RUN is ignored. Latched config does not change mid-run.
- Transfer = idx_valid && idx_ready. Each transfer advances the tuple, innermost first:
  - col++. When col == num_bands_m1, col wraps and row++.
  - When row == num_bands_m1 (with col wrap), row wraps and pix++.
  - When col wraps in sym_mode, col reloads to the new row value, not 0. On pixel wrap row=0 and col=0.
- Output stability: while idx_valid && !idx_ready, all index/flag outputs hold unchanged. idx_valid stays 1 in RUN until the final transfer.
- Flags are combinational from the current tuple and latched bounds:
  - first_of_pixel = (row==0 && col==0).
  - last_of_pixel = (row==num_bands_m1 && col==num_bands_m1).
  - last = last_of_pixel && pix==num_pixels_m1.
- Final transfer (transfer && last):
  - Next cycle: state IDLE, busy=0, idx_valid=0, done=1 for exactly one cycle.
  - Index outputs return to 0.
- start in the done cycle is accepted (state is IDLE). The new run starts the following cycle.
- abort in RUN:
  - Next cycle: IDLE, idx_valid=0, busy=0, indices 0, no done pulse.
  - abort takes priority over a coincident transfer.
  - abort in IDLE has no effect.
- Degenerate bounds:
  - num_bands_m1=0 gives one tuple per pixel, with first and last_of_pixel both 1.
  - Both bounds 0 gives exactly one transfer, with last=1.
- Tuples per pixel:
  - Full mode: (N)^2, where N = num_bands_m1 + 1.
  - Sym mode: N(N+1)/2.
- Arithmetic is unsigned. Counters never exceed the latched bound. No overflow is possible at the maximum bounds (all-ones).

Decomposition:
- Shared package (lcmv_pkg): state enum {IDLE, RUN}, and an index-tuple struct typedef {pix, row, col} parameterised by the package-level IDX_W/PIX_W defaults.
- Sub-module: reuse counter_up_to three times (col, row, pix), wired as follows:
  - up driven by transfer and the inner counter's max.
  - reset_count driven by accepted start and abort.
  - last driven by the latched bounds.
- Sym-mode col reload needs a load path. Add a thin wrapper counter_up_to_load (counter_up_to plus a synchronous load value) rather than modifying the shared counter.

Test Plan:
- Full mode, bands_m1=2, pixels_m1=1, idx_ready=1 -> 18 transfers in order (0,0,0),(0,0,1)...(1,2,2). last only on (1,2,2). done one cycle later. busy high 18 cycles.
- Sym mode, bands_m1=2, pixels_m1=0 -> exactly (0,0),(0,1),(0,2),(1,1),(1,2),(2,2). first_of_pixel on tuple 1. last_of_pixel and last on tuple 6.
- Backpressure: random idx_ready at 30% -> identical sequence to the no-stall run. Outputs bit-stable on every stalled cycle. done count = 1.
- Degenerate: bands_m1=0, pixels_m1=0 -> single tuple (0,0,0) with first_of_pixel=last_of_pixel=last=1, then done.
- Abort after 5 transfers, coincident with idx_ready=1 -> idx_valid=0 next cycle, no done. A following start restarts at (0,0,0).
- Start asserted mid-run with new bounds -> ignored, original sequence completes. Start in the done cycle -> second run begins next cycle with the new bounds. Async rst low mid-run -> all outputs 0 immediately.
